// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch sequencer states, opcode constants and
// instruction-byte field positions used by the fetch stage and the decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_JUMP,
        S_HALT
    } state_e;

    localparam logic [7:0] DEF_HALT_OP = 8'hFF;
    localparam logic [1:0] JMP_PREFIX  = 2'b11;

    // Decoder select lives in A[2:0]; instruction class in [7:6]
    localparam int SEL_MSB   = 2;
    localparam int SEL_LSB   = 0;
    localparam int CLASS_MSB = 7;
    localparam int CLASS_LSB = 6;

    function automatic logic is_jump_op(input logic [7:0] op);
        return op[CLASS_MSB:CLASS_LSB] == JMP_PREFIX;
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous reset to RESET_PC, absolute load for jumps,
// and modulo-2^ADDR_W increment. o_pc_next exposes the value after this edge.
module pc_counter #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_next
);

    logic [ADDR_W-1:0] r_pc;

    // Load has priority; the two are never requested together by the sequencer
    always_comb begin
        o_pc_next = r_pc;
        if (i_load) begin
            o_pc_next = i_load_val;
        end else if (i_inc) begin
            o_pc_next = r_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= o_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch/sequence stage ahead of the 3-to-8 decoder: fetches bytes over req/ack,
// strobes each plain opcode to the decoder for one cycle, handles JUMP and HALT.
module instr_fetch_seq
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [7:0]        HALT_OP  = DEF_HALT_OP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        dec_a,
    output logic              dec_disable,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    state_e            r_state;
    logic [7:0]        r_ir;
    logic [7:0]        r_dec_a;
    logic              r_dec_disable;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_halted;

    logic              w_fetch_ack;
    logic              w_jump_ack;
    logic [ADDR_W-1:0] w_jump_target;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_next;

    // Ack only counts in the two requesting states
    assign w_fetch_ack   = (r_state == S_FETCH) && mem_ack;
    assign w_jump_ack    = (r_state == S_JUMP) && mem_ack;
    assign w_jump_target = ADDR_W'(mem_rdata);

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_jump_ack),
        .i_load_val (w_jump_target),
        .i_inc      (w_fetch_ack),
        .o_pc       (w_pc),
        .o_pc_next  (w_pc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ir          <= '0;
            r_dec_a       <= '0;
            r_dec_disable <= 1'b1;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_halted      <= 1'b0;
        end else begin
            r_dec_disable <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state    <= S_FETCH;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_pc_next;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir      <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (r_ir == HALT_OP) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (is_jump_op(r_ir)) begin
                        r_state    <= S_JUMP;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_pc_next;
                    end else begin
                        r_state       <= S_EXEC;
                        r_dec_a       <= r_ir;
                        r_dec_disable <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (run) begin
                        r_state    <= S_FETCH;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_pc_next;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_JUMP: begin
                    // Operand becomes the new PC; request stays up if fetching resumes
                    if (mem_ack) begin
                        if (run) begin
                            r_state    <= S_FETCH;
                            r_mem_addr <= w_pc_next;
                        end else begin
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                S_HALT: begin
                    r_mem_req <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign dec_a       = r_dec_a;
    assign dec_disable = r_dec_disable;
    assign pc          = w_pc;
    assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Randomized scoreboard bench for instr_fetch_seq: a program-level interpreter
// predicts fetch addresses and decode strobes; memory and strobe monitors check them.
module tb_instr_fetch_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] dec_a;
    logic       dec_disable;
    logic [7:0] pc;
    logic       halted;

    always #5 clk = ~clk;

    instr_fetch_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .dec_a       (dec_a),
        .dec_disable (dec_disable),
        .pc          (pc),
        .halted      (halted)
    );

    logic [7:0] mem [0:255];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_strobe_q [$];
    logic [7:0] exp_addr_q [$];
    int         strobe_cyc_q [$];
    int         cyc = 0;
    int         ws_lo = 0;
    int         ws_hi = 0;
    int         drop_on_strobe = 0;
    int         strobe_cnt = 0;
    bit         mm_busy = 1'b0;
    int         mm_cnt = 0;
    logic [7:0] mm_addr = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic fail_now(input string name, input int act);
        n_checks++;
        $display("FAIL %s: got %0d (0x%0h) expected nothing", name, act, act);
    endtask

    // Reference interpreter: walks the program as the ISA defines it
    function automatic logic [7:0] model_run(input int max_strobes);
        logic [7:0] p = 8'h00;
        int n = 0;
        for (int step = 0; step < 1000; step++) begin
            logic [7:0] op;
            if (max_strobes > 0 && n == max_strobes) break;
            exp_addr_q.push_back(p);
            op = mem[p];
            p = p + 8'd1;
            if (op == 8'hFF) break;
            if (op[7:6] == 2'b11) begin
                exp_addr_q.push_back(p);
                p = mem[p];
            end else begin
                exp_strobe_q.push_back(op);
                n++;
            end
        end
        return p;
    endfunction

    // Memory responder: random wait states, junk data and spurious acks when idle
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req !== 1'b1) begin
                mm_busy   = 1'b0;
                mem_ack   = 1'($urandom_range(1, 0));
                mem_rdata = 8'($urandom);
            end else begin
                if (!mm_busy) begin
                    mm_busy = 1'b1;
                    mm_addr = mem_addr;
                    mm_cnt  = $urandom_range(ws_hi, ws_lo);
                end else begin
                    check("req_addr_stable", mem_addr, mm_addr);
                end
                if (mm_cnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    mm_busy   = 1'b0;
                    $display("fetch  t=%0t addr=%02h data=%02h", $time, mem_addr, mem_rdata);
                    if (exp_addr_q.size() == 0) fail_now("unexpected_fetch", mem_addr);
                    else check("fetch_addr", mem_addr, exp_addr_q.pop_front());
                end else begin
                    mm_cnt--;
                    mem_ack   = 1'b0;
                    mem_rdata = 8'($urandom);
                end
            end
        end
    end

    // Decode strobe monitor
    initial begin
        forever begin
            @(negedge clk);
            if (dec_disable === 1'b0) begin
                strobe_cnt++;
                strobe_cyc_q.push_back(cyc);
                $display("strobe t=%0t dec_a=%02h", $time, dec_a);
                if (exp_strobe_q.size() == 0) fail_now("unexpected_strobe", dec_a);
                else check("strobe_dec_a", dec_a, exp_strobe_q.pop_front());
                if (drop_on_strobe != 0 && strobe_cnt == drop_on_strobe) run = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic clear_sb();
        exp_strobe_q.delete();
        exp_addr_q.delete();
        strobe_cyc_q.delete();
        strobe_cnt = 0;
        drop_on_strobe = 0;
    endtask

    task automatic restart(input int max_strobes, output logic [7:0] fpc);
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        clear_sb();
        fpc   = model_run(max_strobes);
        rst_n = 1'b1;
        run   = 1'b1;
    endtask

    task automatic wait_halted(input string name, input int budget);
        int k = 0;
        while (halted !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_halt_reached"}, int'(halted), 1);
    endtask

    task automatic check_halt_state(input string name, input logic [7:0] exp_pc);
        int reqs = 0;
        check({name, "_halted"}, int'(halted), 1);
        check({name, "_dec_disable"}, int'(dec_disable), 1);
        check({name, "_pc"}, pc, exp_pc);
        repeat (20) begin
            @(negedge clk);
            if (mem_req !== 1'b0) reqs++;
        end
        check({name, "_req_quiet"}, reqs, 0);
        check({name, "_strobes_left"}, exp_strobe_q.size(), 0);
        check({name, "_fetches_left"}, exp_addr_q.size(), 0);
    endtask

    initial begin
        logic [7:0] fpc;
        int k;
        int reqs;

        // Reset held with run=1, then a three-instruction program ending in HALT
        fill_mem(8'hFF);
        mem[0] = 8'h05; mem[1] = 8'h02; mem[2] = 8'h07; mem[3] = 8'hFF;
        ws_lo = 0; ws_hi = 0;
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_mem_req", int'(mem_req), 0);
            check("rst_dec_disable", int'(dec_disable), 1);
            check("rst_pc", pc, 0);
            check("rst_halted", int'(halted), 0);
            check("rst_dec_a", dec_a, 0);
            check("rst_mem_addr", mem_addr, 0);
        end
        clear_sb();
        fpc   = model_run(0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_mem_req", int'(mem_req), 1);
        check("rel_mem_addr", mem_addr, 0);
        wait_halted("plain", 200);
        check("plain_strobe_count", strobe_cyc_q.size(), 3);
        if (strobe_cyc_q.size() == 3) begin
            check("plain_gap1", strobe_cyc_q[1] - strobe_cyc_q[0], 3);
            check("plain_gap2", strobe_cyc_q[2] - strobe_cyc_q[1], 3);
        end
        check("plain_dec_a_hold", dec_a, 8'h07);
        check_halt_state("plain", fpc);

        // Wait states on a single fetch
        fill_mem(8'hFF);
        mem[0] = 8'h03; mem[1] = 8'hFF;
        ws_lo = 4; ws_hi = 4;
        restart(0, fpc);
        wait_halted("wait", 200);
        check("wait_strobe_count", strobe_cnt, 1);
        check_halt_state("wait", fpc);

        // Jump, then a plain op at FF wraps the PC to 00; run dropped after it
        fill_mem(8'hFF);
        mem[8'h00] = 8'hC0; mem[8'h01] = 8'h10; mem[8'h10] = 8'h04;
        mem[8'h11] = 8'hC5; mem[8'h12] = 8'hFF; mem[8'hFF] = 8'h06;
        ws_lo = 0; ws_hi = 0;
        restart(2, fpc);
        drop_on_strobe = 2;
        k = 0;
        while (run === 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("jump_run_dropped", int'(run), 0);
        repeat (6) @(negedge clk);
        check("jump_wrap_pc", pc, fpc);
        check("jump_idle_req", int'(mem_req), 0);
        check("jump_not_halted", int'(halted), 0);
        check("jump_strobes_left", exp_strobe_q.size(), 0);
        check("jump_fetches_left", exp_addr_q.size(), 0);

        // Halt absorbs run=1; reset clears it
        fill_mem(8'hFF);
        mem[0] = 8'h01; mem[1] = 8'hFF;
        ws_lo = 0; ws_hi = 1;
        restart(0, fpc);
        wait_halted("halt", 200);
        check_halt_state("halt", fpc);
        rst_n = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        check("halt_rst_halted", int'(halted), 0);
        check("halt_rst_pc", pc, 0);

        // run dropped during a waited fetch: completes, executes, goes idle
        fill_mem(8'hFF);
        mem[0] = 8'h03; mem[1] = 8'h09; mem[2] = 8'hFF;
        ws_lo = 4; ws_hi = 4;
        restart(1, fpc);
        repeat (2) @(negedge clk);
        check("drop_in_wait_req", int'(mem_req), 1);
        run = 1'b0;
        k = 0;
        while (strobe_cnt < 1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("drop_strobe_seen", strobe_cnt, 1);
        reqs = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_req !== 1'b0) reqs++;
        end
        check("drop_idle_req", reqs, 0);
        check("drop_pc", pc, fpc);
        check("drop_strobes_left", exp_strobe_q.size(), 0);

        // Reset in the middle of a waited fetch abandons it with no strobe
        run = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_req_before", int'(mem_req), 1);
        rst_n = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        check("midrst_req_dropped", int'(mem_req), 0);
        check("midrst_pc", pc, 0);
        rst_n = 1'b1;
        reqs = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req !== 1'b0) reqs++;
        end
        check("midrst_quiet", reqs, 0);
        check("midrst_no_strobe", strobe_cnt, 1);

        // Random forward-jumping programs, HALT at FF so PC ends wrapped to 00
        for (int t = 0; t < 4; t++) begin
            int a;
            int tgt;
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(8'hBF, 0));
            a = 0;
            while (a <= 252) begin
                if ($urandom_range(2, 0) == 0) begin
                    mem[a]     = 8'hC0 + 8'($urandom_range(62, 0));
                    tgt        = $urandom_range(255, a + 2);
                    mem[a + 1] = 8'(tgt);
                    a          = tgt;
                end else begin
                    a++;
                end
            end
            mem[255] = 8'hFF;
            ws_lo = 0; ws_hi = 2;
            restart(0, fpc);
            wait_halted("rand", 5000);
            check_halt_state("rand", fpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
